rggen_apb_register_host: RTL
============================

Name: rggen_apb_register_host

Overview:
- APB-to-register-bus host bridge: initiator side of the register access protocol consumed by the bit-field blocks.
- Converts each APB transfer into one register request with a byte-expanded write mask, waits for the register-side response, and returns read data and an error flag to APB.
- Adds unmapped-address detection and a bounded-wait timeout so a hung register block cannot stall the bus.

Parameters:
- ADDRESS_WIDTH, 16, width of paddr and o_reg_address.
- DATA_WIDTH, 32, data width; a multiple of 8, at least 8.
- TIMEOUT_CYCLES, 16, maximum BUSY cycles before a forced error completion; 0 disables the timeout.
- ERROR_ON_UNMAPPED, 1, 1 means a request with no active register returns pslverr=1; 0 means it returns no error.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- i_psel  in  1  APB select.
- i_penable  in  1  APB enable.
- i_pwrite  in  1  APB direction; 1 = write.
- i_paddr  in  ADDRESS_WIDTH  APB byte address.
- i_pstrb  in  DATA_WIDTH/8  APB write byte strobes.
- i_pwdata  in  DATA_WIDTH  APB write data.
- o_pready  out  1  APB ready; a one-cycle pulse.
- o_prdata  out  DATA_WIDTH  APB read data.
- o_pslverr  out  1  APB error.
- o_reg_valid  out  1  register request valid.
- o_reg_write  out  1  register request direction; 1 = write.
- o_reg_address  out  ADDRESS_WIDTH  word-aligned request address.
- o_reg_write_data  out  DATA_WIDTH  request write data.
- o_reg_write_mask  out  DATA_WIDTH  per-bit write enable.
- i_reg_active  in  1  OR of all register address matches for the current request.
- i_reg_ready  in  1  register response valid.
- i_reg_read_data  in  DATA_WIDTH  OR-combined register read data.
- i_reg_error  in  1  register-side error.

Behaviour:
- Reset: state IDLE, timeout counter 0, every output 0.
- Reset asserted mid-transfer aborts the transfer. No pready is issued for it.

States IDLE -> BUSY -> RESP -> IDLE:
- IDLE: on a setup cycle (i_psel=1, i_penable=0), capture the request fields and go to BUSY. All other cycles are ignored.
- Captured fields:
  - o_reg_write = i_pwrite.
  - o_reg_address = i_paddr with the low log2(DATA_WIDTH/8) bits forced to 0.
  - o_reg_write_data = i_pwdata.
  - o_reg_write_mask = each i_pstrb bit replicated to 8 bits for writes; all ones for reads.
- BUSY: o_reg_valid=1 and the request fields are held stable. Completion is evaluated each cycle in this priority order:
  1. i_reg_active=0 (unmapped): complete with read data 0 and error = ERROR_ON_UNMAPPED. i_reg_ready is ignored.
  2. i_reg_ready=1: complete with error = i_reg_error. Read data = i_reg_read_data for reads, 0 for writes.
  3. TIMEOUT_CYCLES != 0 and the counter equals TIMEOUT_CYCLES-1: complete with read data 0 and error 1.
  4. Otherwise increment the counter and stay in BUSY.
- Completion registers o_prdata and o_pslverr, clears the counter, drops o_reg_valid on the next cycle, and moves to RESP.
- RESP: o_pready=1 for exactly one cycle, then IDLE.
- o_prdata and o_pslverr hold their values until the next completion.

Timing:
- Minimum transfer: setup at T, o_reg_valid at T+1, ready at T+1, pready at T+2 (one APB wait state).
- With TIMEOUT_CYCLES=N, the forced-error completion occurs on the Nth BUSY cycle. pready follows one cycle later.

Boundary and corner cases:
- i_psel or i_penable dropping during BUSY (protocol violation): the request still completes and pready still pulses.
- A new setup is accepted only in IDLE. A setup on the RESP cycle is ignored.
- Back-to-back transfers are supported: setup on the cycle after RESP is accepted.
- i_reg_ready while i_reg_active=0: the unmapped rule wins.
- The timeout counter is wide enough for TIMEOUT_CYCLES and saturates, never wraps.

Test Plan:
- Write, paddr=0x0012, pstrb=4'b0101, pwdata=0xAABBCCDD, ready on the first BUSY cycle -> o_reg_address=0x0010, write_mask=0x00FF00FF, pready at T+2, pslverr=0.
- Read, paddr=0x0020, i_reg_read_data=0x12345678, ready after 3 BUSY cycles -> write_mask=0xFFFFFFFF, prdata=0x12345678, pready on cycle T+4, pslverr=0.
- Read with i_reg_active=0 -> pslverr=1, prdata=0, pready at T+2; repeat with ERROR_ON_UNMAPPED=0 -> pslverr=0.
- TIMEOUT_CYCLES=4, i_reg_active=1, i_reg_ready never asserted -> o_reg_valid high exactly 4 cycles, pslverr=1, prdata=0; a second transfer then completes normally.
- rst pulsed during BUSY -> all outputs 0 next cycle, no pready; the following read completes with correct data.
- Two back-to-back writes with i_reg_error=1 on the second -> first pslverr=0, second pslverr=1; each o_reg_valid window is distinct.

Source files
------------

// File: rtl/rggen_apb_register_host.sv
// APB-to-register-bus host bridge: one register request per APB transfer.
// Ports: clk/rst, APB slave (i_p*/o_p*), register host (o_reg_*/i_reg_*).
module rggen_apb_register_host #(
    parameter int ADDRESS_WIDTH     = 16,
    parameter int DATA_WIDTH        = 32,
    parameter int TIMEOUT_CYCLES    = 16,
    parameter int ERROR_ON_UNMAPPED = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_psel,
    input  logic                     i_penable,
    input  logic                     i_pwrite,
    input  logic [ADDRESS_WIDTH-1:0] i_paddr,
    input  logic [DATA_WIDTH/8-1:0]  i_pstrb,
    input  logic [DATA_WIDTH-1:0]    i_pwdata,
    output logic                     o_pready,
    output logic [DATA_WIDTH-1:0]    o_prdata,
    output logic                     o_pslverr,
    output logic                     o_reg_valid,
    output logic                     o_reg_write,
    output logic [ADDRESS_WIDTH-1:0] o_reg_address,
    output logic [DATA_WIDTH-1:0]    o_reg_write_data,
    output logic [DATA_WIDTH-1:0]    o_reg_write_mask,
    input  logic                     i_reg_active,
    input  logic                     i_reg_ready,
    input  logic [DATA_WIDTH-1:0]    i_reg_read_data,
    input  logic                     i_reg_error
);

    localparam int SW  = DATA_WIDTH / 8;
    localparam int LSB = (SW > 1) ? $clog2(SW) : 0;
    localparam int CW  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    localparam logic [ADDRESS_WIDTH-1:0] ALIGN = {ADDRESS_WIDTH{1'b1}} << LSB;
    localparam logic [CW-1:0] CNT_MAX  = '1;
    localparam logic [CW-1:0] CNT_LAST =
        CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_e;

    state_e                     state_q, state_d;
    logic [CW-1:0]              cnt_q, cnt_d;
    logic                       write_q, write_d;
    logic [ADDRESS_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]      wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]      mask_q, mask_d;
    logic [DATA_WIDTH-1:0]      prdata_q, prdata_d;
    logic                       pslverr_q, pslverr_d;
    logic [DATA_WIDTH-1:0]      strb_mask;
    logic                       timeout_hit;

    always_comb begin
        strb_mask = '0;
        for (int i = 0; i < SW; i++) begin
            strb_mask[i*8 +: 8] = {8{i_pstrb[i]}};
        end
    end

    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        write_d   = write_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        mask_d    = mask_q;
        prdata_d  = prdata_q;
        pslverr_d = pslverr_q;
        case (state_q)
            IDLE: begin
                if (i_psel && !i_penable) begin
                    write_d = i_pwrite;
                    addr_d  = i_paddr & ALIGN;
                    wdata_d = i_pwdata;
                    mask_d  = i_pwrite ? strb_mask : '1;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                // Unmapped beats ready; ready beats timeout.
                if (!i_reg_active) begin
                    prdata_d  = '0;
                    pslverr_d = (ERROR_ON_UNMAPPED != 0);
                    cnt_d     = '0;
                    state_d   = RESP;
                end else if (i_reg_ready) begin
                    prdata_d  = write_q ? '0 : i_reg_read_data;
                    pslverr_d = i_reg_error;
                    cnt_d     = '0;
                    state_d   = RESP;
                end else if (timeout_hit) begin
                    prdata_d  = '0;
                    pslverr_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = RESP;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            write_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            mask_q    <= '0;
            prdata_q  <= '0;
            pslverr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            write_q   <= write_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            mask_q    <= mask_d;
            prdata_q  <= prdata_d;
            pslverr_q <= pslverr_d;
        end
    end

    assign o_pready         = (state_q == RESP);
    assign o_prdata         = prdata_q;
    assign o_pslverr        = pslverr_q;
    assign o_reg_valid      = (state_q == BUSY);
    assign o_reg_write      = write_q;
    assign o_reg_address    = addr_q;
    assign o_reg_write_data = wdata_q;
    assign o_reg_write_mask = mask_q;

endmodule
